cycle_event_seq: RTL and testbench

Cycle-event sequencer that sits directly downstream of the free-running generated clock in the basic-delay test suite. After a start request it counts clock cycles and emits one tagged event per cycle: odd/even parity plus a final marker. Events go over a valid/ready handshake to the log/checker stage, and the sequencer stalls under backpressure. Once the final event is accepted it raises a sticky done flag, which is the trigger the bench uses to end simulation.

---
 rtl/cycle_event_seq.sv | 78 +++++++
 tb/tb_cycle_event_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cycle_event_seq.sv
// Cycle-event sequencer: after start, emits one tagged event per counted cycle
// (parity + final marker) over valid/ready, then raises a sticky done flag.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | counting cycles, loading an event whenever the slot is free
// DRAIN | final event loaded, waiting for it to be accepted
// DONE  | final event accepted, done held high, start restarts
module cycle_event_seq #(
  parameter int LIMIT = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [CNT_W-1:0] cyc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(LIMIT + 1);

  state_t           state;
  logic             accept;
  logic             slot_free;
  logic             last;
  logic [CNT_W-1:0] cyc_next;

  assign accept    = evt_valid & evt_ready;
  assign slot_free = ~evt_valid | accept;
  assign cyc_next  = cyc + CNT_W'(1);
  assign last      = (cyc_next == LAST_CYC);
  assign busy      = (state == RUN) || (state == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_code  <= 2'b00;
      cyc       <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            cyc      <= '0;
            evt_code <= 2'b00;
            done     <= 1'b0;
          end
        end
        RUN: begin
          // Counting only advances when the slot frees, so a stall never skips a cycle.
          if (slot_free) begin
            cyc       <= cyc_next;
            evt_valid <= 1'b1;
            evt_code  <= {last, ~cyc_next[0]};
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept) begin
            evt_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cycle_event_seq.sv
// Bench for cycle_event_seq: scoreboarded event sequences at LIMIT=20 and a
// vector table for a LIMIT=1 instance.
module tb_cycle_event_seq;

  localparam int LIM = 20;

  logic       clk = 1'b0;
  logic       rst, start, evt_ready;
  logic       evt_valid, busy, done;
  logic [1:0] evt_code;
  logic [7:0] cyc;

  logic       rst1, start1, evt_ready1;
  logic       evt_valid1, busy1, done1;
  logic [1:0] evt_code1;
  logic [1:0] cyc1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] cyc;
    logic [1:0] code;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic       rst, start, ready;
    logic       valid, busy, done, chk;
    logic [1:0] code;
    logic [1:0] cyc;
  } vec_t;
  vec_t tbl[12];
  vec_t vq[$];

  always #5 clk = ~clk;

  cycle_event_seq #(.LIMIT(LIM), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .cyc(cyc),
    .busy(busy), .done(done)
  );

  cycle_event_seq #(.LIMIT(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .evt_valid(evt_valid1),
    .evt_ready(evt_ready1), .evt_code(evt_code1), .cyc(cyc1),
    .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sequence from IDLE/DONE; optional stall at one cycle number and
  // start pokes during RUN (cyc 7) and DRAIN.
  task automatic run_seq(input int stall_cyc, input int stall_n, input bit poke_run,
                         input bit poke_drain, input int exp_done);
    int  e;
    int  left;
    bit  pop;
    bit  fin;
    ev_t ev;
    exp_q.delete();
    for (int n = 1; n <= LIM + 1; n++) begin
      ev.cyc     = 8'(n);
      ev.code[1] = (n == LIM + 1);
      ev.code[0] = ~n[0];
      exp_q.push_back(ev);
    end
    left = stall_n;
    start = 1'b1;
    evt_ready = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    chk("busy_after_start", busy, 1);
    chk("done_clear_after_start", done, 0);
    chk("valid_after_start", evt_valid, 0);
    fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      pop = 1'b0;
      start = 1'b0;
      evt_ready = 1'b1;
      if (done) begin
        fin = 1'b1;
      end else begin
        chk("busy_running", busy, 1);
        if (evt_valid) begin
          if (exp_q.size() == 0) begin
            chk("extra_event", 1, 0);
          end else begin
            chk("evt_cyc", cyc, exp_q[0].cyc);
            chk("evt_code", evt_code, exp_q[0].code);
          end
          if (int'(cyc) == stall_cyc && left > 0) begin
            evt_ready = 1'b0;
            left--;
          end else begin
            pop = 1'b1;
          end
          if (poke_run && cyc == 8'd7) start = 1'b1;
          if (poke_drain && evt_code[1]) start = 1'b1;
        end
        tick();
        e++;
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    start = 1'b0;
    evt_ready = 1'b1;
    if (!fin) chk("done_timeout", 0, 1);
    chk("done_edge", e, exp_done);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", evt_valid, 0);
    chk("events_remaining", exp_q.size(), 0);
    repeat (2) begin
      tick();
      chk("done_sticky", done, 1);
      chk("idle_valid_after_done", evt_valid, 0);
    end
  endtask

  initial begin
    bit   found;
    vec_t v;

    rst = 1'b1; start = 1'b0; evt_ready = 1'b1;
    rst1 = 1'b1; start1 = 1'b0; evt_ready1 = 1'b1;
    repeat (2) tick();
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst1_valid", evt_valid1, 0);
    chk("rst1_done", done1, 0);
    rst = 1'b0; rst1 = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", evt_valid, 0);

    run_seq(0, 0, 1'b0, 1'b0, LIM + 2);
    run_seq(5, 3, 1'b0, 1'b0, LIM + 5);
    run_seq(0, 0, 1'b1, 1'b1, LIM + 2);

    // Reset while cyc=10 pending, with start asserted alongside: rst must win.
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (evt_valid && cyc == 8'd10) found = 1'b1;
      else tick();
    end
    chk("reach_cyc10", found, 1);
    rst = 1'b1; start = 1'b1; evt_ready = 1'b0;
    tick();
    rst = 1'b0; start = 1'b0; evt_ready = 1'b1;
    chk("midrst_valid", evt_valid, 0);
    chk("midrst_cyc", cyc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (3) begin
      tick();
      chk("post_rst_no_event", evt_valid, 0);
      chk("post_rst_idle", busy, 0);
    end
    run_seq(0, 0, 1'b0, 1'b0, LIM + 2);

    // LIMIT=1 instance, one row per clock.
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'd2};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0};
    for (int i = 0; i < 12; i++) begin
      rst1 = tbl[i].rst;
      start1 = tbl[i].start;
      evt_ready1 = tbl[i].ready;
      vq.push_back(tbl[i]);
      tick();
      v = vq.pop_front();
      chk($sformatf("l1_valid[%0d]", i), evt_valid1, v.valid);
      chk($sformatf("l1_busy[%0d]", i), busy1, v.busy);
      chk($sformatf("l1_done[%0d]", i), done1, v.done);
      if (v.chk) chk($sformatf("l1_cyc[%0d]", i), cyc1, v.cyc);
      if (v.valid) chk($sformatf("l1_code[%0d]", i), evt_code1, v.code);
    end
    rst1 = 1'b0; start1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
